instruction_memory: RTL
=======================

Name: instruction_memory

Overview:
- Byte-addressed instruction store that answers the CPU's instruction fetch: takes the PC, returns the 32-bit instruction after a fixed multi-cycle latency, and holds the CPU with a busywait handshake.
- Sits between the program counter output and the CPU instruction input.
- A byte-wide load port lets the testbench or boot loader write the program image.

Parameters:
- ADDR_WIDTH, 10, byte address width; the array holds 2**ADDR_WIDTH bytes.
- READ_LATENCY, 4, cycles from read acceptance to data valid; legal range is 1 to 15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- read  input  1  fetch request from the CPU; level-sensitive.
- address  input  ADDR_WIDTH  byte address of the instruction (the PC); bits [1:0] are ignored.
- readdata  output  32  fetched instruction.
- busywait  output  1  high while a fetch is in progress; the CPU stalls the PC while high.
- load_en  input  1  program-load byte write strobe.
- load_addr  input  ADDR_WIDTH  program-load byte address.
- load_data  input  8  program-load byte.
- load_ready  output  1  high when a load write will be accepted.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset (rising edge with reset=1):
  - state=IDLE, counter=0, latched address=0, readdata=32'h0.
  - The memory array is NOT cleared.
  - Reset overrides any other event on that edge, including aborting an in-flight read. The CPU must re-request.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - busywait = read (combinational).
  - load_ready = !read.
  - On an edge with read=1: latch address with bits [1:0] forced to 0.
    - If READ_LATENCY=1, go to DONE and load readdata on that edge.
    - Otherwise load counter=READ_LATENCY-2 and go to BUSY.
- BUSY:
  - busywait=1, load_ready=0.
  - read and address are ignored; the latched address is used.
  - Each edge decrements the counter.
  - On the edge where counter==0: readdata <= {mem[a+3], mem[a+2], mem[a+1], mem[a]} (little-endian, a = latched address), then go to DONE.
- DONE:
  - busywait=0, load_ready=0, readdata valid.
  - The next edge goes unconditionally to IDLE.
  - A read still high in the following IDLE cycle starts a new access (the CPU has advanced the PC on the DONE edge).
- Latency:
  - read is sampled high in cycle 0.
  - busywait is high for cycles 0 to READ_LATENCY-1.
  - Data is valid with busywait low in cycle READ_LATENCY.
  - Throughput is one instruction per READ_LATENCY+1 cycles under a continuous read.
- readdata holds its last value in IDLE and BUSY. It changes only on a completion edge or on reset.
- Address wrap: a+1..a+3 are computed modulo 2**ADDR_WIDTH. Because a is word-aligned, no wrap occurs within a word.
- Load port:
  - A write occurs on an edge where load_en && load_ready: mem[load_addr] <= load_data.
  - load_en while load_ready=0 is silently dropped.
  - A read and a load in the same IDLE cycle: the read wins and the load is dropped.
- Uninitialised array bytes read as X in simulation. The bench must load every fetched word first.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the default READ_LATENCY constant, so the CPU-side stall logic and any future data memory can reuse them.
- Sub-module imem_array: byte RAM with one synchronous write port and a 4-byte combinational read at a word-aligned address. The FSM, counter and handshake logic stay in instruction_memory.

Test Plan:
1. Load bytes 0x00..0x03 = 08,04,00,02, then read=1 with address=0 -> busywait high for 4 cycles; in cycle 4 busywait=0 and readdata=32'h02000408.
2. Misaligned fetch: address=6, word at byte 4 = 32'hDEADBEEF -> readdata=32'hDEADBEEF.
3. Continuous read with address stepping 0,4,8 on each DONE -> three completions 5 cycles apart; address changes during BUSY do not affect data.
4. Assert reset in cycle 2 of a read -> next cycle state IDLE, readdata=0; busywait equals read; the array is unchanged, so a re-read returns the original word.
5. load_en during BUSY with load_addr=0, load_data=FF -> load_ready=0 and the write is dropped; a re-read of address 0 returns the old word.
6. READ_LATENCY=1 build: read at address 0 -> busywait high 1 cycle, data valid in the next cycle, one instruction per 2 cycles.

Source files
------------

// File: rtl/instruction_memory_pkg.sv
// Shared definitions for the instruction-fetch memory path.
//   imem_state_t         : fetch FSM state encoding (IDLE/BUSY/DONE)
//   DEFAULT_READ_LATENCY : default fetch latency in cycles
// Kept separate so the CPU stall logic and a future data memory can reuse them.
package instruction_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } imem_state_t;

  localparam int DEFAULT_READ_LATENCY = 4;

endpackage

// File: rtl/imem_array.sv
// Byte-wide instruction RAM.
// One synchronous byte write port and a combinational 4-byte little-endian
// read of the word selected by word_addr.
//   clk       : clock
//   we        : byte write enable
//   waddr     : byte write address
//   wdata     : byte write data
//   word_addr : word index (byte address >> 2) to read
//   rdata     : {mem[a+3], mem[a+2], mem[a+1], mem[a]}
module imem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [ADDR_WIDTH-3:0] word_addr,
  output logic [31:0]           rdata
);

  logic [7:0] mem [2**ADDR_WIDTH];

  // Contents are deliberately never cleared; reset does not touch the image.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The word is aligned, so the byte lane index simply fills the low two bits
  // and no carry into the upper address bits can occur.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rdata[8*gi +: 8] = mem[{word_addr, 2'(gi)}];
  end

endmodule

// File: rtl/instruction_memory.sv
// Instruction fetch memory with a fixed multi-cycle latency and busywait stall.
//   clk        : clock
//   reset      : synchronous active-high reset (array contents are kept)
//   read       : fetch request (level)
//   address    : byte address of the instruction; bits [1:0] ignored
//   readdata   : fetched instruction, valid in the DONE cycle
//   busywait   : high while a fetch is pending; CPU stalls the PC
//   load_en    : program-load byte write strobe
//   load_addr  : program-load byte address
//   load_data  : program-load byte
//   load_ready : high when a program-load write will be accepted
import instruction_memory_pkg::*;

module instruction_memory #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [31:0]           readdata,
  output logic                  busywait,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [7:0]            load_data,
  output logic                  load_ready
);

  // The first BUSY cycle already follows the accepting IDLE edge, so the
  // countdown starts two below the latency.
  localparam logic [3:0] CNT_INIT = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

  imem_state_t           state_reg;
  logic [3:0]            counter_reg;
  logic [ADDR_WIDTH-3:0] word_addr_reg;   // latched address, bits [1:0] implicitly 0
  logic [31:0]           readdata_reg;

  logic [ADDR_WIDTH-3:0] array_word_addr;
  logic [31:0]           array_word;
  logic                  load_we;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^address[1:0];

  // In IDLE the array looks at the live PC so a single-cycle latency build can
  // capture data on the accepting edge; afterwards the latched address is used.
  assign array_word_addr = (state_reg == IDLE) ? address[ADDR_WIDTH-1:2] : word_addr_reg;

  // Reset wins over a load on the same edge.
  assign load_we = load_en && load_ready && !reset;

  imem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk       (clk),
    .we        (load_we),
    .waddr     (load_addr),
    .wdata     (load_data),
    .word_addr (array_word_addr),
    .rdata     (array_word)
  );

  always_comb begin
    busywait   = 1'b0;
    load_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        busywait   = read;
        load_ready = !read;
      end
      BUSY:    busywait = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      counter_reg   <= 4'd0;
      word_addr_reg <= '0;
      readdata_reg  <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (read) begin
            word_addr_reg <= address[ADDR_WIDTH-1:2];
            if (READ_LATENCY == 1) begin
              readdata_reg <= array_word;
              state_reg    <= DONE;
            end else begin
              counter_reg <= CNT_INIT;
              state_reg   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (counter_reg == 4'd0) begin
            readdata_reg <= array_word;
            state_reg    <= DONE;
          end else begin
            counter_reg <= counter_reg - 4'd1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign readdata = readdata_reg;

endmodule
